// File: rtl/delay_line_meas.sv
// Purpose: launch 2-phase events into an asynchronous delay chain and time each return in clock cycles.
// Latency: each run takes (return delay + SYNC_STAGES + 1) + GAP + 1 cycles; the result follows the last run by one cycle.
// Backpressure: none. start is ignored while busy and refused with timeout=1 if the line has not settled.
module delay_line_meas #(
  parameter int CNT_W       = 16,
  parameter int RUNS_LOG2   = 2,
  parameter int TIMEOUT     = 1023,
  parameter int GAP         = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             launch_r,
  input  logic             return_r,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycles
);

  localparam int SUM_W = CNT_W + RUNS_LOG2;
  localparam int RUN_W = RUNS_LOG2 + 1;
  localparam int RUNS  = 1 << RUNS_LOG2;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_SETTLE,
    S_DONE,
    S_ABORT
  } state_t;

  state_t                 state_q, state_d;
  logic                   launch_q, launch_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   timeout_q, timeout_d;
  logic [CNT_W-1:0]       cycles_q, cycles_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SUM_W-1:0]       sum_q, sum_d;
  logic [RUN_W-1:0]       run_q, run_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [SYNC_STAGES-1:0] sync_q;

  logic ret_s;
  logic settled;

  // The chain's return is a level that changes at an arbitrary time; only the last flop is trusted.
  assign ret_s   = sync_q[SYNC_STAGES-1];
  assign settled = (ret_s == launch_q);

  // Synchronizer for the asynchronous return request; bit 0 is the first flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], return_r};
    end
  end

  // Next-state and output decode; done is a pulse, every other output holds unless updated.
  always_comb begin
    state_d   = state_q;
    launch_d  = launch_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    timeout_d = timeout_q;
    cycles_d  = cycles_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    run_d     = run_q;
    gap_d     = gap_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (settled) begin
            sum_d   = '0;
            run_d   = '0;
            busy_d  = 1'b1;
            state_d = S_LAUNCH;
          end else begin
            // A stray extra toggle left the line unbalanced: refuse rather than mis-measure.
            done_d    = 1'b1;
            timeout_d = 1'b1;
            cycles_d  = '1;
          end
        end
      end
      S_LAUNCH: begin
        launch_d = ~launch_q;
        cnt_d    = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (settled) begin
          // The matching edge itself is counted, so a run is cnt+1 edges long.
          sum_d   = sum_q + SUM_W'(cnt_q) + SUM_W'(1);
          run_d   = run_q + RUN_W'(1);
          gap_d   = '0;
          state_d = S_SETTLE;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SETTLE: begin
        if (gap_q == GAP_W'(GAP - 1)) begin
          state_d = (run_q == RUN_W'(RUNS)) ? S_DONE : S_LAUNCH;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      S_DONE: begin
        cycles_d  = CNT_W'(sum_q >> RUNS_LOG2);
        done_d    = 1'b1;
        timeout_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end
      S_ABORT: begin
        // launch_r keeps its level so a late return can still settle the line.
        cycles_d  = '1;
        done_d    = 1'b1;
        timeout_d = 1'b1;
        busy_d    = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any measurement silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      launch_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      cycles_q  <= '0;
      cnt_q     <= '0;
      sum_q     <= '0;
      run_q     <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      launch_q  <= launch_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      cycles_q  <= cycles_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      run_q     <= run_d;
      gap_q     <= gap_d;
    end
  end

  assign launch_r = launch_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign timeout  = timeout_q;
  assign cycles   = cycles_q;

endmodule

// File: tb/tb_delay_line_meas.sv
// Bench for delay_line_meas: a responder stands in for the delay chain and returns each launch after a chosen delay.
// Expected results come from per-run delays: run = delay + SYNC_STAGES + 1, result = sum >> RUNS_LOG2.
// Inputs are driven and outputs sampled 2 time units after the rising edge.
module tb_delay_line_meas;
  localparam int CNT_W       = 16;
  localparam int RUNS_LOG2   = 2;
  localparam int TIMEOUT     = 20;
  localparam int GAP         = 4;
  localparam int SYNC_STAGES = 2;
  localparam int RUNS        = 1 << RUNS_LOG2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             return_r = 1'b0;
  logic             launch_r;
  logic             busy;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] cycles;

  int total = 0;
  int bad = 0;
  int launches = 0;
  int align_cnt = 0;
  int dly_tab [256];

  always #5 clk = ~clk;

  delay_line_meas #(
    .CNT_W(CNT_W),
    .RUNS_LOG2(RUNS_LOG2),
    .TIMEOUT(TIMEOUT),
    .GAP(GAP),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .launch_r(launch_r),
    .return_r(return_r),
    .busy(busy),
    .done(done),
    .timeout(timeout),
    .cycles(cycles)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Chain model: launch number n is answered dly_tab[n] whole cycles after its launch edge (-1 = never).
  initial begin : responder
    logic last;
    bit   pend;
    int   cd;
    int   k;
    int   align_seen;
    last = 1'b0; pend = 0; cd = 0; align_seen = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        return_r = 1'b0;
        pend = 0;
        last = 1'b0;
      end else begin
        if (align_cnt != align_seen) begin
          align_seen = align_cnt;
          return_r = launch_r;
        end
        if (launch_r !== last) begin
          last = launch_r;
          k = (launches < 256) ? dly_tab[launches] : 0;
          launches++;
          if (k >= 0) begin
            pend = 1;
            cd = k;
          end
        end
        if (pend) begin
          if (cd == 0) begin
            return_r = ~return_r;
            pend = 0;
          end else begin
            cd--;
          end
        end
      end
    end
  end

  task automatic measure(input string tag, input int d [RUNS], input bit poke);
    int exp_sum, exp_lat, lat, n0;
    bit seen, busy_ok;
    n0 = launches; exp_sum = 0; exp_lat = 1;
    for (int i = 0; i < RUNS; i++) begin
      dly_tab[n0 + i] = d[i];
      exp_sum += d[i] + SYNC_STAGES + 1;
      exp_lat += d[i] + SYNC_STAGES + 1 + GAP + 1;
    end
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    check_eq({tag, "/busy_on"}, busy, 1);
    lat = 0; seen = 0; busy_ok = 1;
    while (!seen && lat < 2000) begin
      start = poke && (lat == 12);
      @(posedge clk); #2;
      lat++;
      if (done) seen = 1;
      else if (!busy) busy_ok = 0;
    end
    start = 1'b0;
    check_eq({tag, "/done_seen"}, seen, 1);
    check_eq({tag, "/latency"}, lat, exp_lat);
    check_eq({tag, "/cycles"}, cycles, exp_sum >> RUNS_LOG2);
    check_eq({tag, "/timeout"}, timeout, 0);
    check_eq({tag, "/busy_at_done"}, busy, 0);
    check_eq({tag, "/busy_held"}, busy_ok, 1);
    check_eq({tag, "/launches"}, launches - n0, RUNS);
    n0 = launches; seen = 0;
    repeat (20) begin
      @(posedge clk); #2;
      if (done) seen = 1;
    end
    check_eq({tag, "/quiet_done"}, seen, 0);
    check_eq({tag, "/quiet_launch"}, launches - n0, 0);
  endtask

  initial begin : main
    int dv [RUNS];
    int n0, lat, nd, first, second, exp_lat;
    bit seen;
    logic [CNT_W-1:0] c1, c2;

    repeat (3) @(posedge clk);
    #2;
    check_eq("rst/launch_r", launch_r, 0);
    check_eq("rst/busy", busy, 0);
    check_eq("rst/done", done, 0);
    check_eq("rst/timeout", timeout, 0);
    check_eq("rst/cycles", cycles, 0);
    rst = 1'b0;
    @(posedge clk); #2;

    dv = '{0, 0, 0, 0};
    measure("loopback", dv, 0);
    dv = '{10, 10, 10, 10};
    measure("fixed10", dv, 0);
    dv = '{10, 11, 10, 12};
    measure("trunc", dv, 0);
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < RUNS; i++) dv[i] = int'($urandom_range(15, 0));
      measure("random", dv, 0);
    end

    // Chain never answers: launch edge, TIMEOUT+1 waiting edges, then the abort edge.
    n0 = launches;
    dly_tab[n0] = -1;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    lat = 0; seen = 0;
    while (!seen && lat < 2000) begin
      @(posedge clk); #2;
      lat++;
      if (done) seen = 1;
    end
    check_eq("abort/done_seen", seen, 1);
    check_eq("abort/latency", lat, TIMEOUT + 3);
    check_eq("abort/timeout", timeout, 1);
    check_eq("abort/cycles", cycles, 16'hFFFF);
    check_eq("abort/launch_r", launch_r, 1);
    check_eq("abort/busy", busy, 0);
    check_eq("abort/launches", launches - n0, 1);

    // Line still unsettled, so the next start is refused at once.
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    check_eq("refuse/done", done, 1);
    check_eq("refuse/timeout", timeout, 1);
    check_eq("refuse/cycles", cycles, 16'hFFFF);
    check_eq("refuse/busy", busy, 0);
    @(posedge clk); #2;
    check_eq("refuse/done_pulse", done, 0);
    check_eq("refuse/launch_r", launch_r, 1);
    align_cnt++;
    repeat (4) @(posedge clk);
    #2;
    for (int i = 0; i < RUNS; i++) dv[i] = int'($urandom_range(15, 0));
    measure("recover", dv, 0);

    // Reset in the wait phase of run 2.
    n0 = launches;
    for (int i = 0; i < RUNS; i++) dly_tab[n0 + i] = 10;
    start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    lat = 0;
    while (launches - n0 < 2 && lat < 500) begin
      @(posedge clk); #2;
      lat++;
    end
    check_eq("midrst/second_launch", launches - n0, 2);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk); #2;
    check_eq("midrst/launch_r", launch_r, 0);
    check_eq("midrst/busy", busy, 0);
    check_eq("midrst/done", done, 0);
    check_eq("midrst/timeout", timeout, 0);
    check_eq("midrst/cycles", cycles, 0);
    rst = 1'b0;
    seen = 0;
    repeat (30) begin
      @(posedge clk); #2;
      if (done) seen = 1;
    end
    check_eq("midrst/no_done", seen, 0);
    check_eq("midrst/no_launch", launches - n0, 2);
    dv = '{0, 0, 0, 0};
    measure("after_rst", dv, 0);

    // start held high: the second run is accepted in the IDLE cycle showing the first done.
    n0 = launches;
    for (int i = 0; i < 2 * RUNS; i++) dly_tab[n0 + i] = 0;
    exp_lat = 1 + RUNS * (SYNC_STAGES + 1 + GAP + 1);
    start = 1'b1;
    @(posedge clk); #2;
    lat = 0; nd = 0; first = 0; second = 0; c1 = '0; c2 = '0;
    while (nd < 2 && lat < 500) begin
      @(posedge clk); #2;
      lat++;
      if (done) begin
        if (nd == 0) begin
          first = lat; c1 = cycles;
        end else begin
          second = lat; c2 = cycles;
        end
        nd++;
      end
    end
    start = 1'b0;
    check_eq("b2b/done_count", nd, 2);
    check_eq("b2b/first_latency", first, exp_lat);
    check_eq("b2b/spacing", second - first, exp_lat + 1);
    check_eq("b2b/cycles1", c1, SYNC_STAGES + 1);
    check_eq("b2b/cycles2", c2, SYNC_STAGES + 1);
    repeat (10) @(posedge clk);
    #2;
    check_eq("b2b/launches", launches - n0, 2 * RUNS);

    for (int i = 0; i < RUNS; i++) dv[i] = int'($urandom_range(15, 0));
    measure("poke", dv, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
